pulse_broaden_multi: RTL

Multi-channel, single-clock pulse stretcher: the parametrised successor to the fixed-length single-bit broadener. Each of CH channels detects a rising edge on its input and drives an active window of a runtime-selectable length, with selectable output polarity and retrigger policy. It sits in front of slow consumers such as LEDs, interrupt lines and cross-clock synchronisers, so that one-cycle strobes become reliably sampleable.

---
 rtl/pulse_broaden_pkg.sv | 22 ++
 rtl/pulse_broaden_multi_if.sv | 24 ++
 rtl/pulse_broaden_ch.sv | 106 ++++++++++
 rtl/pulse_broaden_multi.sv | 51 +++++
 4 files changed

// File: rtl/pulse_broaden_pkg.sv
// Shared constants and helpers for the multi-channel pulse broadener.
// The PHASE and MODE selections are passed as strings and compared against
// these constants. eff_len maps the runtime length to the real window length.
package pulse_broaden_pkg;

   localparam string PHASE_POSITIVE = "POSITIVE";
   localparam string PHASE_NEGATIVE = "NEGATIVE";
   localparam string MODE_RETRIGGER = "RETRIGGER";
   localparam string MODE_FIXED     = "FIXED";

   // A zero length still produces a one-cycle window so that no trigger is lost.
   function automatic logic [31:0] eff_len(input logic [31:0] len_raw);
      logic [31:0] len_eff;
      if (len_raw == 32'd0) begin
         len_eff = 32'd1;
      end else begin
         len_eff = len_raw;
      end
      return len_eff;
   endfunction

endpackage

// File: rtl/pulse_broaden_multi_if.sv
// Bus bundle of the multi-channel pulse broadener.
// The overrun-counter signals exist only when PULSE_BROADEN_OVR_CNT_EN is defined.
interface pulse_broaden_multi_if #(
   parameter int CH    = 4,
   parameter int LEN_W = 8,
   parameter int CNT_W = 8
);

   logic [CH-1:0]       d;
   logic [LEN_W-1:0]    len;
   logic [CH-1:0]       q;
   logic [CH-1:0]       busy;
`ifdef PULSE_BROADEN_OVR_CNT_EN
   logic                ovr_clr;
   logic [CH*CNT_W-1:0] ovr_cnt;

   modport master (output d, len, ovr_clr, input q, busy, ovr_cnt);
   modport slave  (input d, len, ovr_clr, output q, busy, ovr_cnt);
`else
   modport master (output d, len, input q, busy);
   modport slave  (input d, len, output q, busy);
`endif

endinterface

// File: rtl/pulse_broaden_ch.sv
// One channel of the pulse broadener.
// It holds the rising-edge detect, the window down-counter and the registered
// q/busy outputs. With PULSE_BROADEN_OVR_CNT_EN defined it also holds a
// saturating counter of triggers rejected in FIXED mode.
module pulse_broaden_ch
   import pulse_broaden_pkg::*;
#(
   parameter int    LEN_W = 8,
   parameter string PHASE = PHASE_POSITIVE,
   parameter string MODE  = MODE_RETRIGGER,
   parameter int    CNT_W = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             d,
   input  logic [LEN_W-1:0] len,
`ifdef PULSE_BROADEN_OVR_CNT_EN
   input  logic             ovr_clr,
   output logic [CNT_W-1:0] ovr_cnt,
`endif
   output logic             q,
   output logic             busy
);

   localparam logic             ACTIVE_LOW = (PHASE == PHASE_NEGATIVE) ? 1'b1 : 1'b0;
   localparam logic             FIXED_MODE = (MODE == MODE_FIXED) ? 1'b1 : 1'b0;
   localparam logic [LEN_W-1:0] CNT_ZERO   = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] CNT_ONE    = LEN_W'(1'b1);

   logic             d_r;
   logic [LEN_W-1:0] cnt_r;
   logic [LEN_W-1:0] cnt_nxt_s;
   logic [LEN_W-1:0] len_eff_s;
   logic             trig_s;
   logic             accept_s;
   logic             q_r;
   logic             busy_r;

   assign len_eff_s = LEN_W'(eff_len(32'(len)));

   // Trigger qualification and next counter value.
   always_comb begin
      trig_s    = d & ~d_r;
      accept_s  = 1'b0;
      cnt_nxt_s = cnt_r;
      if (trig_s) begin
         // FIXED mode only takes a trigger when idle or in the final active
         // cycle, so the following window joins without a gap.
         if ((cnt_r == CNT_ZERO) || !FIXED_MODE || (cnt_r == CNT_ONE)) begin
            accept_s = 1'b1;
         end else begin
            accept_s = 1'b0;
         end
      end else begin
         accept_s = 1'b0;
      end
      if (accept_s) begin
         cnt_nxt_s = len_eff_s;
      end else if (cnt_r != CNT_ZERO) begin
         cnt_nxt_s = cnt_r - CNT_ONE;
      end else begin
         cnt_nxt_s = CNT_ZERO;
      end
   end

   // Edge-detect register, window counter and registered outputs.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         d_r    <= 1'b0;
         cnt_r  <= CNT_ZERO;
         busy_r <= 1'b0;
         q_r    <= ACTIVE_LOW;
      end else begin
         d_r    <= d;
         cnt_r  <= cnt_nxt_s;
         busy_r <= (cnt_nxt_s != CNT_ZERO);
         q_r    <= (cnt_nxt_s != CNT_ZERO) ^ ACTIVE_LOW;
      end
   end

   assign q    = q_r;
   assign busy = busy_r;

`ifdef PULSE_BROADEN_OVR_CNT_EN
   logic             reject_s;
   logic [CNT_W-1:0] ovr_r;

   assign reject_s = trig_s & ~accept_s;

   // Saturating overrun counter; a clear wins over a simultaneous reject.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         ovr_r <= {CNT_W{1'b0}};
      end else if (ovr_clr) begin
         ovr_r <= {CNT_W{1'b0}};
      end else if (reject_s && (ovr_r != {CNT_W{1'b1}})) begin
         ovr_r <= ovr_r + CNT_W'(1'b1);
      end else begin
         ovr_r <= ovr_r;
      end
   end

   assign ovr_cnt = ovr_r;
`endif

endmodule

// File: rtl/pulse_broaden_multi.sv
// Multi-channel pulse broadener: CH independent pulse_broaden_ch instances that
// share one runtime length input.
// Optional feature macro: PULSE_BROADEN_OVR_CNT_EN adds ovr_clr and the
// per-channel ovr_cnt overrun counters.
module pulse_broaden_multi
   import pulse_broaden_pkg::*;
#(
   parameter int    CH    = 4,
   parameter int    LEN_W = 8,
   parameter string PHASE = PHASE_POSITIVE,
   parameter string MODE  = MODE_RETRIGGER,
   parameter int    CNT_W = 8
) (
   input  logic                 clock,
   input  logic                 rst,
   pulse_broaden_multi_if.slave bus
);

   logic [CH-1:0] q_s;
   logic [CH-1:0] busy_s;
`ifdef PULSE_BROADEN_OVR_CNT_EN
   logic [CH*CNT_W-1:0] ovr_s;
`endif

   for (genvar i = 0; i < CH; i++) begin : g_ch
      pulse_broaden_ch #(
         .LEN_W (LEN_W),
         .PHASE (PHASE),
         .MODE  (MODE),
         .CNT_W (CNT_W)
      ) u_ch (
         .clock   (clock),
         .rst     (rst),
         .d       (bus.d[i]),
         .len     (bus.len),
`ifdef PULSE_BROADEN_OVR_CNT_EN
         .ovr_clr (bus.ovr_clr),
         .ovr_cnt (ovr_s[i*CNT_W +: CNT_W]),
`endif
         .q       (q_s[i]),
         .busy    (busy_s[i])
      );
   end

   assign bus.q    = q_s;
   assign bus.busy = busy_s;
`ifdef PULSE_BROADEN_OVR_CNT_EN
   assign bus.ovr_cnt = ovr_s;
`endif

endmodule
